// File: rtl/reg_native_apb_initiator.sv
// Bridges single reg_native_if requests onto an APB initiator port.
// Waits on PREADY are bounded; failures and illegal requests come back through ack_err.
module reg_native_apb_initiator #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  fsm_clk,
    input  logic                  fsm_rst,
    input  logic                  global_sync_reset_in,
    input  logic                  req_vld,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ack_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ack_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero-width counter is not legal, so a disabled timeout still keeps one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [CNT_W:0]        cnt_inc_s;
    logic                  timeout_hit_s;
    logic                  rst_s;
    logic                  load_req_s;
    logic                  load_resp_s;
    logic                  ack_err_nxt_s;
    logic [DATA_WIDTH-1:0] rd_data_nxt_s;

    logic                  ack_vld_r;
    logic                  ack_err_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;

    assign rst_s         = fsm_rst | global_sync_reset_in;
    assign cnt_inc_s     = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit_s = TO_EN && (cnt_inc_s == TO_LIM);

    // Next-state, wait counter and completion values.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        load_req_s    = 1'b0;
        load_resp_s   = 1'b0;
        ack_err_nxt_s = 1'b0;
        rd_data_nxt_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_vld) begin
                    if (wr_en ^ rd_en) begin
                        load_req_s  = 1'b1;
                        state_nxt_s = ST_SETUP;
                    end else begin
                        // Ambiguous request: complete with an error, no bus cycle.
                        load_resp_s   = 1'b1;
                        ack_err_nxt_s = 1'b1;
                        state_nxt_s   = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    load_resp_s   = 1'b1;
                    ack_err_nxt_s = PSLVERR;
                    if (!pwrite_r && !PSLVERR) begin
                        rd_data_nxt_s = PRDATA;
                    end else begin
                        rd_data_nxt_s = '0;
                    end
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
                    if (timeout_hit_s) begin
                        load_resp_s   = 1'b1;
                        ack_err_nxt_s = 1'b1;
                        state_nxt_s   = ST_RESP;
                    end else begin
                        state_nxt_s = ST_ACCESS;
                    end
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge fsm_clk) begin
        if (rst_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Bus control and ack strobe are decoded from the next state so they align with it.
    always_ff @(posedge fsm_clk) begin
        if (rst_s) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            ack_vld_r <= 1'b0;
        end else begin
            psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
            penable_r <= (state_nxt_s == ST_ACCESS);
            ack_vld_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Request and response holding registers; they only change on accept or completion.
    always_ff @(posedge fsm_clk) begin
        if (rst_s) begin
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pwrite_r  <= 1'b0;
            ack_err_r <= 1'b0;
            rd_data_r <= '0;
        end else begin
            if (load_req_s) begin
                paddr_r  <= addr;
                pwdata_r <= wr_data;
                pwrite_r <= wr_en;
            end
            if (load_resp_s) begin
                ack_err_r <= ack_err_nxt_s;
                rd_data_r <= rd_data_nxt_s;
            end
        end
    end

    assign ack_vld = ack_vld_r;
    assign ack_err = ack_err_r;
    assign rd_data = rd_data_r;
    assign PSEL    = psel_r;
    assign PENABLE = penable_r;
    assign PWRITE  = pwrite_r;
    assign PADDR   = paddr_r;
    assign PWDATA  = pwdata_r;

endmodule

// File: tb/tb_reg_native_apb_initiator.sv
// Directed and randomized bench for reg_native_apb_initiator with a 4-cycle PREADY timeout.
module tb_reg_native_apb_initiator;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          fsm_rst;
    logic          global_sync_reset_in;
    logic          req_vld;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld;
    logic [DW-1:0] rd_data;
    logic          ack_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int checks = 0;
    int errors = 0;

    // Reference view of what the bridge should be presenting.
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic          m_pwrite;
    logic [DW-1:0] m_rdata;
    logic          m_err;

    always #5 clk = ~clk;

    reg_native_apb_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .fsm_clk(clk),
        .fsm_rst(fsm_rst),
        .global_sync_reset_in(global_sync_reset_in),
        .req_vld(req_vld),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wr_data(wr_data),
        .ack_vld(ack_vld),
        .rd_data(rd_data),
        .ack_err(ack_err),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle-time inputs: junk on qualified fields, no request, no ready.
    task automatic idle_inputs();
        req_vld = 1'b0;
        wr_en   = 1'($urandom);
        rd_en   = 1'($urandom);
        addr    = {$urandom, $urandom};
        wr_data = $urandom;
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".psel"},    64'(PSEL),    64'(1'b0));
        chk({tag, ".penable"}, 64'(PENABLE), 64'(1'b0));
        chk({tag, ".ack_vld"}, 64'(ack_vld), 64'(1'b0));
        chk({tag, ".paddr"},   64'(PADDR),   64'(m_paddr));
        chk({tag, ".pwdata"},  64'(PWDATA),  64'(m_pwdata));
        chk({tag, ".pwrite"},  64'(PWRITE),  64'(m_pwrite));
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_rdata));
        chk({tag, ".ack_err"}, 64'(ack_err), 64'(m_err));
    endtask

    // One request issued at a negedge while idle; checks every cycle to the idle after ack.
    task automatic xfer(input string tag, input logic wr, input logic rd,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic [DW-1:0] prd, input logic perr,
                        input bit inject);
        int n_acc;
        req_vld = 1'b1;
        wr_en   = wr;
        rd_en   = rd;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        idle_inputs();
        if (wr == rd) begin
            m_err   = 1'b1;
            m_rdata = '0;
            chk({tag, ".ill_ack"},  64'(ack_vld), 64'(1'b1));
            chk({tag, ".ill_err"},  64'(ack_err), 64'(1'b1));
            chk({tag, ".ill_data"}, 64'(rd_data), 64'(0));
            chk({tag, ".ill_psel"}, 64'(PSEL),    64'(1'b0));
        end else begin
            m_paddr  = a;
            m_pwdata = d;
            m_pwrite = wr;
            chk({tag, ".setup_psel"},    64'(PSEL),    64'(1'b1));
            chk({tag, ".setup_penable"}, 64'(PENABLE), 64'(1'b0));
            chk({tag, ".setup_ack"},     64'(ack_vld), 64'(1'b0));
            chk({tag, ".paddr"},         64'(PADDR),   64'(a));
            chk({tag, ".pwdata"},        64'(PWDATA),  64'(d));
            chk({tag, ".pwrite"},        64'(PWRITE),  64'(wr));
            n_acc = (waits < TO) ? waits + 1 : TO;
            for (int k = 0; k < n_acc; k++) begin
                @(negedge clk);
                req_vld = 1'b0;
                chk({tag, ".acc_psel"},    64'(PSEL),    64'(1'b1));
                chk({tag, ".acc_penable"}, 64'(PENABLE), 64'(1'b1));
                chk({tag, ".acc_ack"},     64'(ack_vld), 64'(1'b0));
                chk({tag, ".acc_paddr"},   64'(PADDR),   64'(a));
                PREADY  = (k == waits);
                PRDATA  = prd;
                PSLVERR = perr;
                if (inject && k == 0) begin
                    req_vld = 1'b1;
                    wr_en   = 1'b1;
                    rd_en   = 1'b0;
                    addr    = ~a;
                    wr_data = ~d;
                end
            end
            @(negedge clk);
            idle_inputs();
            if (waits >= TO) begin
                m_err   = 1'b1;
                m_rdata = '0;
            end else begin
                m_err   = perr;
                m_rdata = (rd && !perr) ? prd : '0;
            end
            chk({tag, ".resp_ack"},     64'(ack_vld), 64'(1'b1));
            chk({tag, ".resp_psel"},    64'(PSEL),    64'(1'b0));
            chk({tag, ".resp_penable"}, 64'(PENABLE), 64'(1'b0));
            chk({tag, ".resp_err"},     64'(ack_err), 64'(m_err));
            chk({tag, ".resp_data"},    64'(rd_data), 64'(m_rdata));
        end
        @(negedge clk);
        check_idle({tag, ".post"});
        if (inject) begin
            @(negedge clk);
            check_idle({tag, ".post2"});
        end
    endtask

    initial begin
        logic wr;
        logic rd;
        int   w;
        fsm_rst              = 1'b1;
        global_sync_reset_in = 1'b0;
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_rdata = '0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        fsm_rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_idle("after_reset");

        xfer("wr_basic", 1'b1, 1'b0, 64'h10, 32'h12345678, 0, 32'h0, 1'b0, 1'b0);
        xfer("rd_wait3", 1'b0, 1'b1, 64'h14, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
        xfer("rd_slverr", 1'b0, 1'b1, 64'h18, 32'h0, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
        xfer("wr_slverr", 1'b1, 1'b0, 64'h1C, 32'hCAFEF00D, 1, 32'h0, 1'b1, 1'b0);
        xfer("rd_timeout", 1'b0, 1'b1, 64'h20, 32'h0, 1000, 32'h55AA55AA, 1'b0, 1'b0);
        xfer("rd_after_to", 1'b0, 1'b1, 64'h24, 32'h0, 0, 32'h0BADF00D, 1'b0, 1'b0);
        xfer("illegal_11", 1'b1, 1'b1, 64'h28, 32'h11111111, 0, 32'h0, 1'b0, 1'b0);
        xfer("illegal_00", 1'b0, 1'b0, 64'h2C, 32'h22222222, 0, 32'h0, 1'b0, 1'b0);
        xfer("rd_inject", 1'b0, 1'b1, 64'h30, 32'h0, 2, 32'h13572468, 1'b0, 1'b1);

        // Soft reset in the middle of an ACCESS phase.
        req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 64'h34; wr_data = 32'h0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("srst.in_access", 64'(PENABLE), 64'(1'b1));
        global_sync_reset_in = 1'b1;
        @(negedge clk);
        global_sync_reset_in = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_rdata = '0; m_err = 1'b0;
        check_idle("srst.cleared");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("srst.no_ack");
        end
        xfer("wr_after_srst", 1'b1, 1'b0, 64'h38, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? wr : ~wr;
            w  = $urandom_range(0, 5);
            xfer("rand", wr, rd, {$urandom, $urandom}, $urandom, w, $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_native_apb_initiator.md
# reg_native_apb_initiator

Bridge that accepts single register accesses on the reg_native_if responder side (req_vld/ack_vld, as driven by a regmst or a parent regslv) and issues them as APB initiator transactions to a downstream APB register slave. It is the APB-driving end of the path that regmst terminates: regmst turns APB into reg_native_if, this block turns reg_native_if back into APB. It adds a bounded wait on PREADY and reports failures on a separate error flag.

## Interface
- ADDR_WIDTH, 64: native and APB address width
- DATA_WIDTH, 32: native and APB data width
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles with PREADY low before abort; 0 disables timeout; counter width is clog2(TIMEOUT_CYCLES+1)

- fsm_clk  in  1  single clock for native and APB sides
- fsm_rst  in  1  reset, synchronous, active-high
- global_sync_reset_in  in  1  synchronous soft reset; same effect as fsm_rst
- req_vld  in  1  one-cycle request strobe from upstream
- wr_en  in  1  request is a write; qualified by req_vld
- rd_en  in  1  request is a read; qualified by req_vld
- addr  in  ADDR_WIDTH  request address; qualified by req_vld
- wr_data  in  DATA_WIDTH  write data; qualified by req_vld
- ack_vld  out  1  one-cycle completion strobe
- rd_data  out  DATA_WIDTH  read data; valid with ack_vld
- ack_err  out  1  completion carried an error; valid with ack_vld
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: the block samples req_vld. If req_vld=1 and exactly one of wr_en/rd_en is 1, it latches addr into PADDR, wr_data into PWDATA, and wr_en into PWRITE, then moves to SETUP.
- IDLE, req_vld=1 with wr_en=rd_en (both 0 or both 1): illegal request. No APB cycle is issued. The block goes to RESP with ack_err=1 and rd_data=0.
- SETUP: PSEL=1, PENABLE=0. Next state is always ACCESS. The timeout counter clears here.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PSLVERR into ack_err. For a read with PSLVERR=0, capture PRDATA into rd_data; otherwise rd_data=0. Go to RESP.
  - PREADY=0: the counter increments. When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0), abort: ack_err=1, rd_data=0, go to RESP.
- RESP: ack_vld=1 for exactly one cycle, PSEL=PENABLE=0. Next state is IDLE.
- req_vld in SETUP, ACCESS or RESP is ignored; no queuing. Upstream must wait for ack_vld before issuing the next request.
- A write always returns rd_data=0.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. They hold their last values while IDLE; they are not cleared after a transfer.
- rd_data and ack_err hold their values after ack_vld falls, until the next completion.

## Timing
- Reset (fsm_rst or global_sync_reset_in high at a clock edge) forces:
  - FSM to IDLE and counter to 0;
  - ack_vld=0, ack_err=0, rd_data=0;
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Reset has priority over every other event. Reset in the middle of a transaction drops PSEL immediately and never produces an ack for the aborted request.
- All outputs are registered; there is no combinational path from input to output.
- Latency, with req_vld=1 sampled at edge N and PREADY=1 in the first ACCESS cycle:
  - SETUP in cycle N+1;
  - ACCESS in cycle N+2;
  - ack_vld in cycle N+3.
- Each PREADY=0 ACCESS cycle adds one cycle of latency.
- Illegal request: ack_vld in cycle N+1.
- Timeout: a slave that never asserts PREADY gives TIMEOUT_CYCLES ACCESS cycles, then ack_vld with ack_err=1 in the following cycle.
- Back-to-back: the earliest next req_vld is accepted in the cycle after ack_vld (IDLE). Minimum spacing between APB SETUP phases is 4 cycles.

## Test plan
- Write 0x12345678 to addr 0x10, PREADY=1 at once: PSEL rises at N+1, PENABLE at N+2, PWRITE=1, PWDATA=0x12345678; ack_vld at N+3 with ack_err=0, rd_data=0.
- Read addr 0x14, slave holds PREADY low 3 cycles then returns PRDATA=0xDEADBEEF: ACCESS lasts 4 cycles; ack_vld at N+6 with rd_data=0xDEADBEEF, ack_err=0.
- Read with PREADY=1 and PSLVERR=1, PRDATA=0xFFFFFFFF: ack_err=1, rd_data=0. A following write with PSLVERR=1: ack_err=1.
- TIMEOUT_CYCLES=4, PREADY tied low: exactly 4 ACCESS cycles, PSEL falls, ack_vld with ack_err=1, rd_data=0. Next request then completes normally.
- req_vld with wr_en=rd_en=1: PSEL never asserts; ack_vld at N+1 with ack_err=1. A req_vld pulse during ACCESS of a prior read is ignored: only one ack is produced.
- global_sync_reset_in pulsed during ACCESS: PSEL=PENABLE=0 next cycle, no ack_vld, all outputs at reset values. A subsequent write completes with 3-cycle latency.
